// File: rtl/approx_mult_pkg.sv
// Shared mode constants and helpers for the pipelined approximate multiplier.
// The testbench reuses comp4_approx so it follows the same 4:2 compressor rule.
package approx_mult_pkg;

  typedef enum logic {
    MODE_EXACT  = 1'b0,
    MODE_APPROX = 1'b1
  } mode_e;

  // Number of partial-product bits landing in column k of a width x width array.
  function automatic int col_height(input int width, input int k);
    if (k < 0 || k > 2 * width - 2) return 0;
    return (k < width) ? k + 1 : 2 * width - 1 - k;
  endfunction

  // Approximate 4:2 compressor: returns {carry, sum}.
  function automatic logic [1:0] comp4_approx(input logic [3:0] x);
    logic w1;
    logic w2;
    w1 = x[0] | x[1];
    w2 = x[2] | x[3];
    return {w1 & w2, w1 ^ w2};
  endfunction

endpackage

// File: rtl/approx_col_compress.sv
// One product column: either passes its partial products through unchanged or
// replaces them with approximate 4:2 group outputs (sums at weight k, carries at k+1).
module approx_col_compress
  import approx_mult_pkg::*;
#(
  parameter int K           = 0,
  parameter int H           = 1,
  parameter int APPROX_COLS = 0,
  localparam int G          = (H + 3) / 4
) (
  input  logic         mode,
  input  logic [H-1:0] col,
  output logic [H-1:0] bits,
  output logic [G-1:0] carries
);

  localparam bit COL_APPROX = (K < APPROX_COLS);

  logic [4*G-1:0] padded;
  logic [1:0]     cs;

  // Bit 0 of col is the lowest row; groups of four are zero-padded at the top.
  assign padded = (4*G)'(col);

  always_comb begin
    bits    = col;
    carries = '0;
    cs      = '0;
    if (COL_APPROX && mode == MODE_APPROX) begin
      bits = '0;
      for (int g = 0; g < G; g++) begin
        cs         = comp4_approx(padded[4*g +: 4]);
        bits[g]    = cs[0];
        carries[g] = cs[1];
      end
    end
  end

endmodule

// File: rtl/approx_mult_pipe.sv
// Pipelined WIDTH x WIDTH unsigned multiplier with per-beat exact/approximate mode.
// Optional error monitor (exact shadow product, err_mag/err_max) under APPROX_ERR_MON_EN.
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_approx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               out_approx
`ifdef APPROX_ERR_MON_EN
  ,
  output logic [2*WIDTH-1:0] err_mag,
  output logic [2*WIDTH-1:0] err_max
`endif
);

  localparam int PW   = 2 * WIDTH;
  localparam int NCOL = 2 * WIDTH - 1;

  // Handshake: a beat moves across an interface on a rising edge where valid and
  // ready are both high; valid and its data hold until that edge, ready may be
  // combinational from downstream ready, and a stage loads when its register is
  // empty or is being emptied in the same cycle.
  logic v1, v2, v3;
  logic stage1_ready, stage2_ready, stage3_ready;

  assign stage3_ready = ~v3 | out_ready;
  assign stage2_ready = ~v2 | stage3_ready;
  assign stage1_ready = ~v1 | stage2_ready;
  assign in_ready     = stage1_ready;

  logic [WIDTH-1:0] bits_d  [NCOL];
  logic [WIDTH-1:0] carry_d [NCOL];

  for (genvar k = 0; k < NCOL; k++) begin : g_col
    localparam int H   = col_height(WIDTH, k);
    localparam int ILO = (k < WIDTH) ? 0 : k - WIDTH + 1;
    localparam int G   = (H + 3) / 4;

    logic [H-1:0] col;
    logic [H-1:0] bits;
    logic [G-1:0] carries;

    // col[m] is pp[i][j] with row i = ILO+m ascending.
    for (genvar m = 0; m < H; m++) begin : g_pp
      assign col[m] = in_a[k-ILO-m] & in_b[ILO+m];
    end

    approx_col_compress #(
      .K           (k),
      .H           (H),
      .APPROX_COLS (APPROX_COLS)
    ) u_cmp (
      .mode    (in_approx),
      .col     (col),
      .bits    (bits),
      .carries (carries)
    );

    assign bits_d[k]  = WIDTH'(bits);
    assign carry_d[k] = WIDTH'(carries);
  end

  // Stage 1: compressed column bits.
  logic [WIDTH-1:0] s1_bits  [NCOL];
  logic [WIDTH-1:0] s1_carry [NCOL];
  logic             s1_approx;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      s1_approx <= 1'b0;
      for (int k = 0; k < NCOL; k++) begin
        s1_bits[k]  <= '0;
        s1_carry[k] <= '0;
      end
    end else if (stage1_ready) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_approx <= in_approx;
        for (int k = 0; k < NCOL; k++) begin
          s1_bits[k]  <= bits_d[k];
          s1_carry[k] <= carry_d[k];
        end
      end
    end
  end

  // Carry-save reduction of every bit row down to a sum row and a carry row.
  logic [PW-1:0] acc_s, acc_c, row, crow, tsum;

  always_comb begin
    acc_s = '0;
    acc_c = '0;
    row   = '0;
    crow  = '0;
    tsum  = '0;
    for (int r = 0; r < WIDTH; r++) begin
      row  = '0;
      crow = '0;
      for (int k = 0; k < NCOL; k++) begin
        row[k]    = s1_bits[k][r];
        crow[k+1] = s1_carry[k][r];
      end
      tsum  = acc_s ^ acc_c ^ row;
      acc_c = ((acc_s & acc_c) | (acc_s & row) | (acc_c & row)) << 1;
      acc_s = tsum;
      tsum  = acc_s ^ acc_c ^ crow;
      acc_c = ((acc_s & acc_c) | (acc_s & crow) | (acc_c & crow)) << 1;
      acc_s = tsum;
    end
  end

  logic [PW-1:0] s2_s, s2_c, s3_p;
  logic          s2_approx, s3_approx;

  always_ff @(posedge clk) begin
    if (rst) begin
      v2        <= 1'b0;
      s2_s      <= '0;
      s2_c      <= '0;
      s2_approx <= 1'b0;
    end else if (stage2_ready) begin
      v2 <= v1;
      if (v1) begin
        s2_s      <= acc_s;
        s2_c      <= acc_c;
        s2_approx <= s1_approx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v3        <= 1'b0;
      s3_p      <= '0;
      s3_approx <= 1'b0;
    end else if (stage3_ready) begin
      v3 <= v2;
      if (v2) begin
        s3_p      <= s2_s + s2_c;
        s3_approx <= s2_approx;
      end
    end
  end

  assign out_valid  = v3;
  assign out_p      = s3_p;
  assign out_approx = s3_approx;

`ifdef APPROX_ERR_MON_EN
  logic [PW-1:0] s1_exact, s2_exact, s3_exact;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_exact <= '0;
      s2_exact <= '0;
      s3_exact <= '0;
    end else begin
      if (stage1_ready && in_valid) s1_exact <= PW'(in_a) * PW'(in_b);
      if (stage2_ready && v1)       s2_exact <= s1_exact;
      if (stage3_ready && v2)       s3_exact <= s2_exact;
    end
  end

  // Approximation only ever drops weight, so the difference is non-negative.
  assign err_mag = s3_approx ? (s3_exact - s3_p) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_max <= '0;
    end else if (out_valid && out_ready && (err_mag > err_max)) begin
      err_max <= err_mag;
    end
  end
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Bench for approx_mult_pipe: directed vectors, random backpressure stream, full-pipe
// accept/drain, mid-flight reset; covers err_mag/err_max when APPROX_ERR_MON_EN is set.
module tb_approx_mult_pipe;
  import approx_mult_pkg::*;

  localparam int WIDTH = 8;
  localparam int COLS  = 8;
  localparam int PW    = 2 * WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic             in_valid, in_approx, out_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic             in_ready, out_valid, out_approx;
  logic [PW-1:0]    out_p;
  logic             in_ready0, out_valid0, out_approx0;
  logic [PW-1:0]    out_p0;
`ifdef APPROX_ERR_MON_EN
  logic [PW-1:0]    err_mag, err_max, err_mag0, err_max0;
`endif

  approx_mult_pipe #(.WIDTH(WIDTH), .APPROX_COLS(COLS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_approx  (in_approx),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_p      (out_p),
    .out_approx (out_approx)
`ifdef APPROX_ERR_MON_EN
    ,
    .err_mag    (err_mag),
    .err_max    (err_max)
`endif
  );

  // Zero approximate columns: must behave as an exact multiplier in both modes.
  approx_mult_pipe #(.WIDTH(WIDTH), .APPROX_COLS(0)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready0),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_approx  (in_approx),
    .out_valid  (out_valid0),
    .out_ready  (1'b1),
    .out_p      (out_p0),
    .out_approx (out_approx0)
`ifdef APPROX_ERR_MON_EN
    ,
    .err_mag    (err_mag0),
    .err_max    (err_max0)
`endif
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: column-by-column sum straight from the partial-product rules.
  function automatic logic [PW-1:0] ref_mult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic m, input int cols);
    longint     total;
    int         n;
    logic       cb [WIDTH];
    logic [3:0] grp;
    logic [1:0] cs;
    total = 0;
    for (int k = 0; k < 2 * WIDTH - 1; k++) begin
      n = 0;
      for (int i = 0; i < WIDTH; i++) begin
        if (k - i >= 0 && k - i < WIDTH) begin
          cb[n] = a[k-i] & b[i];
          n++;
        end
      end
      if (m && k < cols) begin
        for (int g = 0; g < n; g += 4) begin
          grp = '0;
          for (int t = 0; t < 4; t++) if (g + t < n) grp[t] = cb[g+t];
          cs = comp4_approx(grp);
          total += longint'(cs[0]) << k;
          total += longint'(cs[1]) << (k + 1);
        end
      end else begin
        for (int t = 0; t < n; t++) total += longint'(cb[t]) << k;
      end
    end
    return total[PW-1:0];
  endfunction

  // ---------------- scoreboard ----------------
  logic [PW-1:0] exp_q[$];
  logic          exp_mode_q[$];
  logic [PW-1:0] exp_exact_q[$];
  int            acc_cyc_q[$];
  logic [PW-1:0] exp0_q[$];
  logic [PW-1:0] out_log[$];
  logic          mode_log[$];
  logic [PW-1:0] err_log[$];

  int            inflight   = 0;
  logic          held_valid = 1'b0;
  logic [PW-1:0] held_p;
  logic          held_mode;
  logic          lat_chk    = 1'b0;
  logic [PW-1:0] exp_max    = '0;

  always @(negedge clk) begin
    logic [PW-1:0] e_p, e_x;
    logic          e_m;
    int            c;
    if (rst) begin
      exp_q.delete(); exp_mode_q.delete(); exp_exact_q.delete(); acc_cyc_q.delete();
      exp0_q.delete();
      inflight   = 0;
      held_valid = 1'b0;
      exp_max    = '0;
    end else begin
      check("in_ready_rule", in_ready, !(inflight == 3 && !out_ready));
      if (held_valid) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_p", out_p, held_p);
        check("hold_mode", out_approx, held_mode);
      end
      held_valid = out_valid && !out_ready;
      held_p     = out_p;
      held_mode  = out_approx;

      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", out_valid, 1'b0);
        end else begin
          e_p = exp_q.pop_front();
          e_m = exp_mode_q.pop_front();
          e_x = exp_exact_q.pop_front();
          c   = acc_cyc_q.pop_front();
          check("out_p", out_p, e_p);
          check("out_approx", out_approx, e_m);
          if (lat_chk) check("latency", cyc - c, 3);
          out_log.push_back(out_p);
          mode_log.push_back(out_approx);
`ifdef APPROX_ERR_MON_EN
          check("err_mag", err_mag, e_x - e_p);
          check("err_max", err_max, exp_max);
          if (e_x - e_p > exp_max) exp_max = e_x - e_p;
          err_log.push_back(err_mag);
`endif
          inflight--;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_mult(in_a, in_b, in_approx, COLS));
        exp_mode_q.push_back(in_approx);
        exp_exact_q.push_back(PW'(in_a) * PW'(in_b));
        acc_cyc_q.push_back(cyc);
        inflight++;
      end

      if (out_valid0) begin
        if (exp0_q.size() == 0) check("spurious_out0", out_valid0, 1'b0);
        else check("out_p_cols0", out_p0, exp0_q.pop_front());
      end
      if (in_valid && in_ready0) exp0_q.push_back(PW'(in_a) * PW'(in_b));
    end
  end

  // ---------------- driver ----------------
  logic acc_now, drain_now;

  task automatic step();
    @(negedge clk);
    acc_now   = in_valid && in_ready;
    drain_now = out_valid && out_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic m);
    in_a      = a;
    in_b      = b;
    in_approx = m;
  endtask

  task automatic set_random_beat();
    set_beat(WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_beat('0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_p", out_p, '0);
    check("rst_out_approx", out_approx, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Directed back-to-back vectors, no backpressure.
    lat_chk = 1'b1;
    out_log.delete(); mode_log.delete(); err_log.delete();
    in_valid = 1'b1;
    set_beat(8'hFF, 8'hFF, 1'b0); step();
    set_beat(8'hFF, 8'hFF, 1'b1); step();
    set_beat(8'hFF, 8'hFF, 1'b0); step();
    set_beat(8'h01, 8'h01, 1'b1); step();
    set_beat(8'h00, 8'hFF, 1'b1); step();
    in_valid = 1'b0;
    repeat (6) step();
    lat_chk = 1'b0;
    check("dir_count", out_log.size(), 5);
    if (out_log.size() >= 5) begin
      check("dir_ff_exact", out_log[0], 16'hFE01);
      check("dir_ff_approx", out_log[1], 16'hFAAB);
      check("dir_ff_exact2", out_log[2], 16'hFE01);
      check("dir_1x1", out_log[3], 16'h0001);
      check("dir_0xff", out_log[4], 16'h0000);
      check("dir_mode0", mode_log[0], 1'b0);
      check("dir_mode1", mode_log[1], 1'b1);
    end
`ifdef APPROX_ERR_MON_EN
    if (err_log.size() >= 3) begin
      check("dir_err_exact", err_log[0], 0);
      check("dir_err_approx", err_log[1], 854);
      check("dir_err_follow", err_log[2], 0);
    end
    check("dir_err_max", err_max, 854);
`endif

    // Random stream with random backpressure.
    n = 0;
    in_valid = 1'b1;
    set_random_beat();
    for (int c = 0; c < 400 && n < 16; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
      if (acc_now) begin
        n++;
        if (n < 16) set_random_beat();
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("stream_accepts", n, 16);
    out_ready = 1'b1;
    repeat (6) step();
    check("stream_drained", exp_q.size(), 0);

    // Fill the pipe with out_ready low, then accept and drain together.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_random_beat();
      step();
      check("fill_accept", acc_now, 1'b1);
    end
    set_random_beat();
    step();
    check("full_stall", acc_now, 1'b0);
    out_ready = 1'b1;
    step();
    check("accept_with_drain", acc_now, 1'b1);
    check("drain_with_accept", drain_now, 1'b1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      set_random_beat();
      step();
      if (acc_now) cnt++;
    end
    check("sustained_rate", cnt, 8);
    in_valid = 1'b0;
    repeat (6) step();
    check("full_drained", exp_q.size(), 0);

    // Reset with three beats in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_random_beat();
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_p", out_p, '0);
    check("mid_rst_in_ready", in_ready, 1'b1);
`ifdef APPROX_ERR_MON_EN
    check("mid_rst_err_max", err_max, '0);
`endif
    out_ready = 1'b1;
    repeat (6) step();
    in_valid = 1'b1;
    set_beat(8'hA5, 8'h3C, 1'b1);
    step();
    in_valid = 1'b0;
    repeat (6) step();
    check("post_rst_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/approx_mult_pipe.md
Name: approx_mult_pipe

Overview:
- Parametrised, pipelined successor to the team's 8x8 dual-stage-compressor approximate multiplier.
- Unsigned WIDTH x WIDTH multiply with a full 2*WIDTH-bit product.
- Per-transaction exact/approximate mode; approximation is confined to the low APPROX_COLS columns.
- Sits between operand producers and accumulator/filter datapaths behind a valid/ready stream interface, 3-stage pipeline.

Parameters:
- WIDTH, 8, operand width in bits (4..32).
- APPROX_COLS, WIDTH, number of low product columns (0..2*WIDTH-1) that use the approximate 4:2 compression in approx mode.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_a  in  WIDTH  multiplicand, unsigned.
- in_b  in  WIDTH  multiplier, unsigned.
- in_approx  in  1  1 = approximate mode, 0 = exact, captured with the beat.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts the product.
- out_p  out  2*WIDTH  product.
- out_approx  out  1  mode tag travelling with the product.

Behaviour:
- One clock; reset is synchronous and active-high.
- Partial product pp[i][j] = a[j]&b[i], column k = i+j.
- Approximate reduction, only when in_approx=1 and k<APPROX_COLS:
  - Column bits are ordered by row i ascending and grouped in fours, padding with 0.
  - Each group (x1..x4) gives w1=x1|x2 and w2=x3|x4.
  - The group emits sum=w1^w2 at weight 2^k and carry=w1&w2 at weight 2^(k+1).
  - This is applied once, to the original partial products only.
  - All resulting bits are then summed exactly.
- Columns k>=APPROX_COLS, and all columns in exact mode, are summed exactly.
- Exact mode result must equal a*b bit-for-bit.
- Pipeline:
  - S1 registers the partial products and the approximate group outputs.
  - S2 registers the Wallace/Dadda reduction to two rows.
  - S3 registers the final carry-propagate add.
- Latency: 3 cycles from accept (in_valid&in_ready) to out_valid with no backpressure. Throughput is 1 per cycle.
- Stall rules:
  - Stage n advances when its downstream register is empty or draining.
  - in_ready = ~v1 | advance1, combinational through the ready chain.
  - No bubbles are inserted and no beat is dropped or duplicated.
  - out_p and out_approx hold stable while out_valid & ~out_ready.
- Simultaneous accept and drain in the same cycle is legal when full; throughput is preserved.
- Reset behaviour:
  - All valid bits clear; in-flight beats are discarded.
  - out_valid=0, out_p=0, out_approx=0.
  - in_ready=1 in the first cycle after reset deassertion.
- Data registers update only when their stage advances; no X propagation from idle stages.
- APPROX_COLS=0: approx mode behaves identically to exact mode.

Optional Feature:
- Macro: APPROX_ERR_MON_EN.
- Defined:
  - An exact product is carried alongside every beat.
  - Extra outputs: err_mag (2*WIDTH, = exact-approx, 0 for exact beats) valid with out_valid, and err_max (2*WIDTH).
  - err_max is updated on each output handshake as max(err_max, err_mag) and cleared by rst.
- Undefined: neither port exists and no exact shadow datapath is built.

Decomposition:
- Package approx_mult_pkg holds:
  - The mode constants MODE_EXACT=0 and MODE_APPROX=1.
  - A localparam function computing the column height for given WIDTH/k.
  - A pure function comp4_approx(x[3:0]) returning {carry,sum}, also used by the testbench model.
- One sub-module, approx_col_compress: parametrised on column index k and height. It emits the approximated or passthrough bits for one column, gated by mode, and is instantiated per column in a generate loop.

Test Plan:
- WIDTH=8, APPROX_COLS=8, out_ready=1. Send (a=0xFF,b=0xFF,approx=0) then (0xFF,0xFF,1) back-to-back -> out_p=0xFE01 then 0xFAAB, 3 cycles after each accept, out_approx 0 then 1.
- (1,1,approx=1) -> 0x0001. (0,0xFF,approx=1) -> 0x0000. Both with APPROX_COLS=0 and approx=1 across random operands -> equals a*b.
- Stream 16 random beats with out_ready toggling pseudo-randomly:
  - Order is preserved, no loss or duplication.
  - out_p is stable during stalls.
  - in_ready falls only after all 3 stages are full and out_ready=0.
- Pipeline full and out_ready low. Raise out_ready and in_valid together -> accept and drain occur in the same cycle, with sustained 1/cycle afterwards.
- Assert rst for 1 cycle with 3 beats in flight -> next cycle out_valid=0, out_p=0, in_ready=1, and no stale beat ever appears.
- With APPROX_ERR_MON_EN, (0xFF,0xFF,1) -> err_mag=854 (0x0356), err_max=854. A following exact beat gives err_mag=0 and err_max stays 854.
